// File: rtl/eject_reassembly_pkg.sv
// Shared flit-format definitions and slot state encoding for the eject reassembly block.
// The macros below are the global.v flit format; each is only defined here when
// global.v has not already been read, so the shared values always take precedence.
`ifndef WIDTH_PAYLOAD
`define WIDTH_PAYLOAD 16
`endif
`ifndef WIDTH_FLIT_ID
`define WIDTH_FLIT_ID 2
`endif
`ifndef WIDTH_PKT_ID
`define WIDTH_PKT_ID 8
`endif
`ifndef WIDTH_TIME
`define WIDTH_TIME 8
`endif
`ifndef POS_PAYLOAD
`define POS_PAYLOAD 0
`endif
`ifndef POS_FLIT_ID
`define POS_FLIT_ID 16
`endif
`ifndef POS_PKT_ID
`define POS_PKT_ID 18
`endif
`ifndef POS_TIME
`define POS_TIME 26
`endif
`ifndef WIDTH_PORT
`define WIDTH_PORT 34
`endif

package eject_reassembly_pkg;

    localparam int PAYLOAD_DEF_W = `WIDTH_PAYLOAD;
    localparam int FLIT_ID_W     = `WIDTH_FLIT_ID;
    localparam int PKT_ID_W      = `WIDTH_PKT_ID;
    localparam int TIME_W        = `WIDTH_TIME;
    localparam int POS_PAYLOAD   = `POS_PAYLOAD;
    localparam int POS_FLIT_ID   = `POS_FLIT_ID;
    localparam int POS_PKT_ID    = `POS_PKT_ID;
    localparam int POS_TIME      = `POS_TIME;
    localparam int PORT_W        = `WIDTH_PORT;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_FILLING = 2'd1,
        SLOT_DONE    = 2'd2
    } slotState_t;

endpackage

// File: rtl/eject_reassembly_slot.sv
// One reassembly slot: holds the PktId, FlitId-0 time stamp, received mask and payloads
// of a single packet, and reports whether an incoming flit belongs to it.
module reasm_slot
    import eject_reassembly_pkg::*;
#(
    parameter int FLITS_PER_PKT = 4,
    parameter int PAYLOAD_W     = `WIDTH_PAYLOAD
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wrEn,
    input  logic                                 alloc,
    input  logic                                 freeEn,
    input  logic [PKT_ID_W-1:0]                  pktIdIn,
    input  logic [FLIT_ID_W-1:0]                 flitIdIn,
    input  logic [TIME_W-1:0]                    timeIn,
    input  logic [PAYLOAD_W-1:0]                 payloadIn,
    output logic                                 match,
    output logic                                 isFree,
    output logic                                 done,
    output logic [PKT_ID_W-1:0]                  pktId,
    output logic [TIME_W-1:0]                    stamp,
    output logic [FLITS_PER_PKT*PAYLOAD_W-1:0]   data
);

    slotState_t               state;
    logic [FLITS_PER_PKT-1:0] mask;
    logic [FLITS_PER_PKT-1:0] flitBit;
    logic [FLITS_PER_PKT-1:0] nextMask;

    assign match  = (state == SLOT_FILLING) && (pktId == pktIdIn);
    assign isFree = (state == SLOT_FREE);
    assign done   = (state == SLOT_DONE);

    // Mask after this write; a fresh allocation starts from an empty mask.
    always_comb begin
        flitBit = '0;
        if (int'(flitIdIn) < FLITS_PER_PKT) flitBit[flitIdIn] = 1'b1;
        nextMask = (alloc ? '0 : mask) | flitBit;
    end

    // Slot state, storage and completion; a full mask goes straight to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SLOT_FREE;
            mask  <= '0;
            pktId <= '0;
            stamp <= '0;
            data  <= '0;
        end else if (freeEn) begin
            state <= SLOT_FREE;
            mask  <= '0;
        end else if (wrEn) begin
            if (alloc) pktId <= pktIdIn;
            mask <= nextMask;
            if (flitBit != '0) data[int'(flitIdIn)*PAYLOAD_W +: PAYLOAD_W] <= payloadIn;
            if (flitIdIn == '0) stamp <= timeIn;
            state <= (&nextMask) ? SLOT_DONE : SLOT_FILLING;
        end
    end

endmodule

// File: rtl/eject_reassembly.sv
// Ejection-side packet reassembly: captures every flit leaving the router, steers it to
// a matching or newly allocated slot, and presents completed packets in slot order.
module eject_reassembly
    import eject_reassembly_pkg::*;
#(
    parameter int WIDTH_PORT    = `WIDTH_PORT,
    parameter int FLITS_PER_PKT = 4,
    parameter int NUM_SLOTS     = 4,
    parameter int PAYLOAD_W     = `WIDTH_PAYLOAD
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [WIDTH_PORT-1:0]                din,
    output logic                                 pkt_valid,
    input  logic                                 pkt_ready,
    output logic [PKT_ID_W-1:0]                  pkt_id,
    output logic [TIME_W-1:0]                    pkt_time,
    output logic [FLITS_PER_PKT*PAYLOAD_W-1:0]   pkt_data,
    output logic [15:0]                          drop_cnt
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                  flitValid;
    logic [PKT_ID_W-1:0]   pktIdIn;
    logic [FLIT_ID_W-1:0]  flitIdIn;
    logic [TIME_W-1:0]     timeIn;
    logic [PAYLOAD_W-1:0]  payloadIn;

    assign flitValid = |din;
    assign pktIdIn   = din[POS_PKT_ID  +: PKT_ID_W];
    assign flitIdIn  = din[POS_FLIT_ID +: FLIT_ID_W];
    assign timeIn    = din[POS_TIME    +: TIME_W];
    assign payloadIn = din[POS_PAYLOAD +: PAYLOAD_W];

    logic [NUM_SLOTS-1:0] matchVec, freeVec, doneVec, wrVec, allocVec, freeEnVec;
    logic [PKT_ID_W-1:0]                 slotPktId [NUM_SLOTS];
    logic [TIME_W-1:0]                   slotStamp [NUM_SLOTS];
    logic [FLITS_PER_PKT*PAYLOAD_W-1:0]  slotData  [NUM_SLOTS];

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : gSlot
        reasm_slot #(
            .FLITS_PER_PKT (FLITS_PER_PKT),
            .PAYLOAD_W     (PAYLOAD_W)
        ) uSlot (
            .clk       (clk),
            .reset     (reset),
            .wrEn      (wrVec[g]),
            .alloc     (allocVec[g]),
            .freeEn    (freeEnVec[g]),
            .pktIdIn   (pktIdIn),
            .flitIdIn  (flitIdIn),
            .timeIn    (timeIn),
            .payloadIn (payloadIn),
            .match     (matchVec[g]),
            .isFree    (freeVec[g]),
            .done      (doneVec[g]),
            .pktId     (slotPktId[g]),
            .stamp     (slotStamp[g]),
            .data      (slotData[g])
        );
    end

    logic              anyMatch, anyFree, anyDone, dropFlit, locked;
    logic [SLOT_W-1:0] matchIdx, allocIdx, firstDone, lockIdx, selIdx;

    // Lowest-index matching, free and done slots.
    always_comb begin
        anyMatch  = 1'b0;
        anyFree   = 1'b0;
        anyDone   = 1'b0;
        matchIdx  = '0;
        allocIdx  = '0;
        firstDone = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (matchVec[i]) begin anyMatch = 1'b1; matchIdx  = SLOT_W'(i); end
            if (freeVec[i])  begin anyFree  = 1'b1; allocIdx  = SLOT_W'(i); end
            if (doneVec[i])  begin anyDone  = 1'b1; firstDone = SLOT_W'(i); end
        end
    end

    // Steer the incoming flit: match first, else allocate, else drop. A slot freed this
    // cycle is still DONE here, so it cannot be reallocated until the next cycle.
    always_comb begin
        wrVec    = '0;
        allocVec = '0;
        dropFlit = 1'b0;
        if (flitValid) begin
            if (anyMatch) begin
                wrVec[matchIdx] = 1'b1;
            end else if (anyFree) begin
                wrVec[allocIdx]    = 1'b1;
                allocVec[allocIdx] = 1'b1;
            end else begin
                dropFlit = 1'b1;
            end
        end
    end

    // Presented packet: locked slot while stalled, otherwise lowest DONE slot.
    always_comb begin
        selIdx    = locked ? lockIdx : firstDone;
        pkt_valid = anyDone;
        pkt_id    = anyDone ? slotPktId[selIdx] : '0;
        pkt_time  = anyDone ? slotStamp[selIdx] : '0;
        pkt_data  = anyDone ? slotData[selIdx]  : '0;
        freeEnVec = '0;
        if (anyDone && pkt_ready) freeEnVec[selIdx] = 1'b1;
    end

    // Hold the selection while the consumer stalls so a newly completed lower slot cannot swap it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked  <= 1'b0;
            lockIdx <= '0;
        end else if (pkt_valid && !pkt_ready) begin
            locked  <= 1'b1;
            lockIdx <= selIdx;
        end else begin
            locked  <= 1'b0;
        end
    end

    // Saturating count of flits lost for want of a slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (dropFlit && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: doc/eject_reassembly.md
EJECT_REASSEMBLY -- requirements
Module: eject_reassembly

Interface
REQ-001 Parameter WIDTH_PORT, default `WIDTH_PORT, router output flit width.
REQ-002 Parameter FLITS_PER_PKT, default 4, flits per packet; FlitId range 0..FLITS_PER_PKT-1.
REQ-003 Parameter NUM_SLOTS, default 4, concurrent reassembly slots.
REQ-004 Parameter PAYLOAD_W, default `WIDTH_PAYLOAD, payload bits per flit.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 din  input  WIDTH_PORT  flit from router doutLocal; all-zero means no flit.
REQ-008 pkt_valid  output  1  a complete packet is presented.
REQ-009 pkt_ready  input  1  consumer accepts the packet when high with pkt_valid.
REQ-010 pkt_id  output  `WIDTH_PKT_ID  PktId of the presented packet.
REQ-011 pkt_time  output  `WIDTH_TIME  Time field of the packet's FlitId 0.
REQ-012 pkt_data  output  FLITS_PER_PKT*PAYLOAD_W  payloads; FlitId k occupies bits [k*PAYLOAD_W +: PAYLOAD_W].
REQ-013 drop_cnt  output  16  saturating count of flits discarded for lack of a slot.

Function
REQ-014 A flit is valid when din != 0; the block is capture-only (the router has no backpressure), so it accepts or drops every valid flit in the cycle it is presented.
REQ-015 Each slot holds a state of FREE, FILLING or DONE, plus PktId, Time, a FLITS_PER_PKT-bit received mask and a payload array.
REQ-016 Fields: PktId, FlitId, Time and payload are extracted using the `POS_* field macros.
REQ-017 Match rule: a valid flit whose PktId equals a FILLING slot's PktId writes that slot's payload[FlitId] and sets mask[FlitId].
REQ-018 Allocation rule: on no match, the lowest-index FREE slot moves to FILLING with PktId captured and mask/payload written as in REQ-017.
REQ-019 Duplicate FlitId (mask bit already set): the payload is overwritten and the mask is unchanged; there is no error.
REQ-020 Drop rule: on no match and no FREE slot, the flit is discarded and drop_cnt increments, saturating at 16'hFFFF.
REQ-021 Time is captured into the slot only from FlitId 0.
REQ-022 Completion: when the mask becomes all-ones, the slot moves FILLING->DONE on the same edge.
REQ-023 Output selection: when unlocked, select the lowest-index DONE slot; pkt_valid = 1 when any slot is DONE.
REQ-024 Latency: a final flit presented on din in cycle C gives pkt_valid high in cycle C+1 (pkt_* are combinational from the selected slot).
REQ-025 Hold: while pkt_valid && !pkt_ready, the selection is locked and pkt_id/pkt_time/pkt_data stay stable.
REQ-026 Handshake: pkt_valid && pkt_ready frees the selected slot (DONE->FREE, mask cleared) at that edge and unlocks the selection.
REQ-027 Simultaneous events: a slot freed by a handshake in cycle C is not allocatable until cycle C+1; a flit arriving in C with no other FREE slot is dropped.
REQ-028 Back-to-back: with two DONE slots and pkt_ready held high, one packet is delivered per cycle in index order.
REQ-029 Flits in slots not yet DONE are never presented; no timeout, and a partially filled slot persists until complete.

Reset
REQ-030 Reset asserted: all slots FREE, masks 0, selection unlocked, pkt_valid=0, pkt_id=0, pkt_time=0, pkt_data=0, drop_cnt=0.
REQ-031 Reset asserted mid-operation discards all partial and DONE packets immediately (asynchronously); a flit on din in the first edge after deassertion is processed normally.

Structure
REQ-032 Field widths, field positions and WIDTH_PORT come from the shared global.v definitions; no local redefinition.
REQ-033 A single sub-module, reasm_slot (one slot: state, mask, storage, match output), is instantiated NUM_SLOTS times; allocation and output selection stay in the top.

Verification
REQ-034 Flits PktId=5, FlitId 0,1,2,3 in consecutive cycles C..C+3 with pkt_ready=1 -> pkt_valid=1 in cycle C+4 only, pkt_id=5, payloads in order, slot freed.
REQ-035 Flits of PktId 1 and 2 interleaved, out of FlitId order (3,0,2,1) -> two packets each correctly reassembled; PktId whose last flit arrives first is delivered first.
REQ-036 Four partial packets fill all slots, then a flit with PktId 9 arrives -> flit discarded, drop_cnt=1, existing slots unchanged.
REQ-037 Packet DONE with pkt_ready=0 for 5 cycles while other flits arrive -> pkt_* stable throughout; delivered on the cycle pkt_ready=1.
REQ-038 Duplicate FlitId 2 with a new payload before completion -> completes after 4 distinct FlitIds, payload[2]=latest value.
REQ-039 Reset pulsed with 2 partial packets held -> pkt_valid=0, drop_cnt=0; a fresh 4-flit packet afterwards reassembles correctly.
